// File: rtl/mips24_pkg.sv
// Shared MIPS-24 types and constants used by the fetch stage.
package mips24_pkg;

  localparam int XLEN        = 24;
  localparam int INSTR_BYTES = 3;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode-side valid/ready.
interface fetch_unit_if;
  import mips24_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic            imem_en;
  logic [XLEN-1:0] imem_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_addr, imem_en, out_valid, out_instr, out_pc,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, imem_en, out_valid, out_instr, out_pc,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction FIFO with a registered head; flush drops every entry but lets a same-cycle pop finish.
module fetch_fifo
  import mips24_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [AW:0]  o_count
);

  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  r_head;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_wr;
  logic [AW-1:0] w_rd_next;
  logic [AW:0]   w_after_pop;

  assign w_wr        = i_push && !i_flush;
  assign w_rd_next   = r_rd_ptr + AW'(i_pop);
  assign w_after_pop = r_count - (AW+1)'(i_pop);

  // NOTE: storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  // The head register always holds what the read pointer will address next
  // cycle, so a push into an empty (or emptied) FIFO goes straight to the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_after_pop + (AW+1)'(i_push);
      if (w_after_pop != '0) r_head <= r_mem[w_rd_next];
      else if (i_push)       r_head <= i_data;
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// MIPS-24 fetch stage: owns the PC, issues reads under a FIFO credit limit, absorbs memory latency.
module fetch_unit
  import mips24_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 24'h000000,
  parameter int              DEPTH    = 4
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  fetch_state_t    r_state, w_state_next;
  logic [XLEN-1:0] r_pc, r_inflight_pc;
  logic            r_inflight;

  logic            w_issue, w_pop, w_push;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  fetch_entry_t    w_push_data, w_head;

  assign w_pop       = bus.out_valid && bus.out_ready;
  assign w_push      = r_inflight && !bus.redirect_valid;
  assign w_push_data = '{instr: bus.imem_data, pc: r_inflight_pc};
  // Entries held plus the one outstanding read, less what leaves this cycle.
  assign w_occ       = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};

  always_comb begin
    // NOTE: defaults first, so every path assigns every output (no latches).
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      BOOT: w_state_next = RUN;
      RUN:  w_issue      = !bus.redirect_valid && (w_occ < DEPTH_W);
    endcase
  end

  // NOTE: non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc       <= bus.redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.imem_addr = r_pc;
  assign bus.imem_en   = w_issue;
  assign bus.out_valid = (w_count != '0);
  assign bus.out_instr = w_head.instr;
  assign bus.out_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/redirect traffic vs a stream model.
`timescale 1ns/1ps
module tb_fetch_unit;
  import mips24_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [23:0] RESET_PC = 24'h000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: next PC expected on imem_addr, next PC expected at the decode
  // side, reads issued but not yet consumed, cycles since reset release.
  logic [23:0] m_fetch_pc = RESET_PC;
  logic [23:0] m_exp_pc   = RESET_PC;
  int          m_occ      = 0;
  int          m_cyc      = 0;
  int          m_pops     = 0;

  function automatic logic [23:0] mem_word(input logic [23:0] a);
    case (a)
      24'h000000: return 24'hDEADBE;
      24'h000003: return 24'hFEEDBA;
      24'h000006: return 24'hABCDEF;
      24'h000009: return 24'hC0FFEE;
      default:    return (a * 24'd7) ^ 24'h5A5A5A;
    endcase
  endfunction

  // Instruction memory: one-cycle registered read.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_data <= mem_word(bus.imem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample the current cycle at the falling edge and advance the model.
  task automatic sample();
    bit pop;
    bit en_exp;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_imem_addr", 64'(bus.imem_addr), 64'(RESET_PC));
      check("rst_imem_en",   64'(bus.imem_en),   64'(0));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_out_instr", 64'(bus.out_instr), 64'(0));
      check("rst_out_pc",    64'(bus.out_pc),    64'(0));
      m_fetch_pc = RESET_PC;
      m_exp_pc   = RESET_PC;
      m_occ      = 0;
      m_cyc      = 0;
    end else begin
      pop    = bus.out_valid && bus.out_ready;
      en_exp = (m_cyc >= 1) && !bus.redirect_valid && ((m_occ - int'(pop)) < DEPTH);
      check("imem_addr", 64'(bus.imem_addr), 64'(m_fetch_pc));
      check("imem_en",   64'(bus.imem_en),   64'(en_exp));
      if (pop) begin
        check("stream_pc",    64'(bus.out_pc),    64'(m_exp_pc));
        check("stream_instr", 64'(bus.out_instr), 64'(mem_word(m_exp_pc)));
        m_exp_pc = m_exp_pc + 24'd3;
        m_pops++;
      end
      if (bus.redirect_valid) begin
        m_fetch_pc = bus.redirect_pc;
        m_exp_pc   = bus.redirect_pc;
        m_occ      = 0;
      end else begin
        if (bus.imem_en) m_fetch_pc = m_fetch_pc + 24'd3;
        m_occ = m_occ + int'(bus.imem_en) - int'(pop);
      end
      check("credit_bound", 64'(m_occ <= DEPTH), 64'(1));
      m_cyc++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  initial begin
    logic [23:0] t1_instr [3];
    int n_iss;
    int p0;
    t1_instr[0] = 24'hDEADBE;
    t1_instr[1] = 24'hFEEDBA;
    t1_instr[2] = 24'hABCDEF;

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    tick();
    tick();

    // Boot and first stream: out_valid three cycles after release.
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("t1_no_valid", 64'(bus.out_valid), 64'(0));
      adv();
    end
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t1_valid", 64'(bus.out_valid), 64'(1));
      check("t1_pc",    64'(bus.out_pc),    64'(3 * k));
      check("t1_instr", 64'(bus.out_instr), 64'(t1_instr[k]));
      adv();
    end

    // Stall: exactly DEPTH issues, then fetch holds at 0x0C.
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    n_iss = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      n_iss += int'(bus.imem_en);
      adv();
    end
    sample();
    check("t2_issues",    64'(n_iss),         64'(DEPTH));
    check("t2_en_low",    64'(bus.imem_en),   64'(0));
    check("t2_pc_hold",   64'(bus.imem_addr), 64'(24'h00000C));
    check("t2_full_valid", 64'(bus.out_valid), 64'(1));
    adv();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sample();
      check("t2_drain_valid", 64'(bus.out_valid), 64'(1));
      if (c == 4) check("t2_resume_pc", 64'(bus.out_pc), 64'(24'h00000C));
      adv();
    end

    // Redirect with two entries queued and one read outstanding.
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 24'h000009;
    sample();
    check("t3_en_redirect", 64'(bus.imem_en), 64'(0));
    adv();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    sample();
    check("t3_flushed", 64'(bus.out_valid), 64'(0));
    check("t3_issue",   64'(bus.imem_en),   64'(1));
    adv();
    sample();
    check("t3_stale_dropped", 64'(bus.out_valid), 64'(0));
    adv();
    sample();
    check("t3_valid", 64'(bus.out_valid), 64'(1));
    check("t3_pc",    64'(bus.out_pc),    64'(24'h000009));
    check("t3_instr", 64'(bus.out_instr), 64'(24'hC0FFEE));
    adv();

    // Redirect in a cycle that also pops and would otherwise issue.
    for (int c = 0; c < 5; c++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 24'h000030;
    sample();
    check("t4_pop_valid", 64'(bus.out_valid), 64'(1));
    check("t4_en_low",    64'(bus.imem_en),   64'(0));
    adv();
    bus.redirect_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      sample();
      check("t4_gap", 64'(bus.out_valid), 64'(0));
      adv();
    end
    sample();
    check("t4_new_pc", 64'(bus.out_pc), 64'(24'h000030));
    adv();

    // Redirect near the top of the address space: PC wraps.
    for (int c = 0; c < 3; c++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 24'hFFFFFD;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    sample();
    check("t5_pc0", 64'(bus.out_pc), 64'(24'hFFFFFD));
    adv();
    sample();
    check("t5_pc1", 64'(bus.out_pc), 64'(24'h000000));
    adv();
    sample();
    check("t5_pc2", 64'(bus.out_pc), 64'(24'h000003));
    adv();

    // Asynchronous reset with the FIFO non-empty.
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("t6_pre_valid", 64'(bus.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(bus.out_valid), 64'(0));
    check("t6_async_en",    64'(bus.imem_en),   64'(0));
    tick();
    tick();
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("t6_no_residual", 64'(bus.out_valid), 64'(0));
      adv();
    end
    sample();
    check("t6_restart_pc",    64'(bus.out_pc),    64'(RESET_PC));
    check("t6_restart_instr", 64'(bus.out_instr), 64'(24'hDEADBE));
    adv();

    // Random back-pressure and redirects against the stream model.
    for (int c = 0; c < 400; c++) begin
      bus.out_ready      = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) bus.redirect_pc = 24'hFFFFF0 + 24'($urandom_range(0, 15));
      else                           bus.redirect_pc = 24'($urandom);
      tick();
    end

    // Drain: with decode always ready the stream must keep flowing.
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    p0 = m_pops;
    for (int c = 0; c < 12; c++) tick();
    check("drain_liveness", 64'((m_pops - p0) >= 8), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
